// File: rtl/reel_pkg.sv
// Shared constants and quadrature-phase helpers for the reel rate encoder.
package reel_pkg;

  localparam int unsigned REEL_W    = 9;
  localparam int unsigned REEL_MAX  = 511;
  localparam int unsigned REEL_SLOW = 288;
  localparam int unsigned REEL_FAST = 320;

  // Encoded as {a, b}; forward rotation walks 00 -> 01 -> 11 -> 10 -> 00.
  typedef enum logic [1:0] {
    Ph00 = 2'b00,
    Ph01 = 2'b01,
    Ph11 = 2'b11,
    Ph10 = 2'b10
  } quad_phase_e;

  function automatic quad_phase_e quad_fwd_next(input quad_phase_e ph);
    quad_phase_e nxt;
    unique case (ph)
      Ph00:    nxt = Ph01;
      Ph01:    nxt = Ph11;
      Ph11:    nxt = Ph10;
      Ph10:    nxt = Ph00;
      default: nxt = Ph00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/encoder_debounce.sv
// Two-flop synchronizer plus stability-counter debounce for one encoder pin.
// After reset the level tracks the synced pin directly for DEB_CYCLES cycles.
module encoder_debounce #(
  parameter int unsigned DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level
);

  localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] prime_cnt_q, prime_cnt_d;
  logic            primed_q, primed_d;

  always_comb begin
    level_d     = level_q;
    cnt_d       = cnt_q;
    prime_cnt_d = prime_cnt_q;
    primed_d    = primed_q;
    if (!primed_q) begin
      level_d = sync2_q;
      cnt_d   = '0;
      if (prime_cnt_q == CntLast) begin
        primed_d = 1'b1;
      end else begin
        prime_cnt_d = prime_cnt_q + CntW'(1);
      end
    end else if (sync2_q != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      cnt_q       <= '0;
      prime_cnt_q <= '0;
      primed_q    <= 1'b0;
    end else begin
      sync1_q     <= pin;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      cnt_q       <= cnt_d;
      prime_cnt_q <= prime_cnt_d;
      primed_q    <= primed_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/reel_rate_encoder.sv
// Quadrature encoder -> windowed step rate -> peak-hold/decay reel effort value.
// Define REEL_BIDIR_EN to count reverse steps too and expose the dir output.
module reel_rate_encoder
  import reel_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = 50000,
  parameter int unsigned WINDOW_CYCLES = 2500000,
  parameter int unsigned SCALE         = 16,
  parameter int unsigned DECAY         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enc_a,
  input  logic              enc_b,
  output logic [REEL_W-1:0] reel,
  output logic              reel_valid,
  output logic              step_err
`ifdef REEL_BIDIR_EN
  ,
  output logic              dir
`endif
);

  localparam int unsigned WinW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WinW-1:0]   WinLast   = WinW'(WINDOW_CYCLES - 1);
  // Priming rides on the window counter, so DEB_CYCLES must not exceed WINDOW_CYCLES.
  localparam logic [WinW-1:0]   PrimeLast = WinW'(DEB_CYCLES - 1);
  localparam logic [REEL_W-1:0] DecayAmt  = REEL_W'(DECAY);
  localparam logic [REEL_W-1:0] ReelMax   = REEL_W'(REEL_MAX);

  logic              a_lvl, b_lvl;
  quad_phase_e       cur_ph, prev_q, prev_d;
  logic              fwd_step, both_chg, step;
  logic [7:0]        cnt_q, cnt_d;
  logic [WinW-1:0]   win_cnt_q, win_cnt_d;
  logic [REEL_W-1:0] reel_q, reel_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              primed_q, primed_d;
  logic [31:0]       raw_full;
  logic [REEL_W-1:0] raw;

  encoder_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb_a (
    .clk  (clk),
    .rst  (rst),
    .pin  (enc_a),
    .level(a_lvl)
  );

  encoder_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb_b (
    .clk  (clk),
    .rst  (rst),
    .pin  (enc_b),
    .level(b_lvl)
  );

  assign cur_ph   = quad_phase_e'({a_lvl, b_lvl});
  assign fwd_step = primed_q && (cur_ph == quad_fwd_next(prev_q));
  assign both_chg = primed_q && ((cur_ph ^ prev_q) == 2'b11);

`ifdef REEL_BIDIR_EN
  logic rev_step;
  logic last_rev_q, last_rev_d;
  logic dir_q, dir_d;

  assign rev_step = primed_q && (prev_q == quad_fwd_next(cur_ph));
  assign step     = fwd_step | rev_step;
`else
  assign step     = fwd_step;
`endif

  assign raw_full = 32'(cnt_q) * SCALE;
  assign raw      = (raw_full > 32'(REEL_MAX)) ? ReelMax : raw_full[REEL_W-1:0];

  always_comb begin
    prev_d    = cur_ph;
    cnt_d     = cnt_q;
    win_cnt_d = win_cnt_q + WinW'(1);
    reel_d    = reel_q;
    valid_d   = 1'b0;
    err_d     = both_chg;
    primed_d  = primed_q;
`ifdef REEL_BIDIR_EN
    last_rev_d = last_rev_q;
    dir_d      = dir_q;
    if (step) begin
      last_rev_d = rev_step;
    end
`endif
    if (win_cnt_q == PrimeLast) begin
      primed_d = 1'b1;
    end
    if (win_cnt_q == WinLast) begin
      win_cnt_d = '0;
      valid_d   = 1'b1;
      // A step on the terminal cycle belongs to the next window.
      cnt_d     = step ? 8'd1 : 8'd0;
      if (raw >= reel_q) begin
        reel_d = raw;
      end else begin
        reel_d = (reel_q > DecayAmt) ? (reel_q - DecayAmt) : '0;
      end
`ifdef REEL_BIDIR_EN
      dir_d = last_rev_q;
`endif
    end else if (step && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q    <= Ph00;
      cnt_q     <= '0;
      win_cnt_q <= '0;
      reel_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      primed_q  <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      win_cnt_q <= win_cnt_d;
      reel_q    <= reel_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      primed_q  <= primed_d;
    end
  end

`ifdef REEL_BIDIR_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_rev_q <= 1'b0;
      dir_q      <= 1'b0;
    end else begin
      last_rev_q <= last_rev_d;
      dir_q      <= dir_d;
    end
  end

  assign dir = dir_q;
`endif

  assign reel       = reel_q;
  assign reel_valid = valid_q;
  assign step_err   = err_q;

endmodule

// File: doc/reel_rate_encoder.md
Name: reel_rate_encoder

Overview:
- Produces the 9-bit `reel` effort value consumed by the fishing-game block controller's catch states.
- Decodes a hand-cranked quadrature rotary encoder (Pmod pins `enc_a`/`enc_b`) into counted reel-in steps over a fixed time window.
- Scales each window's count into a 0..511 rate, then applies peak-hold with linear decay.
- Consumer thresholds: `reel[8:5]` > 8 means slow reel; > 9 means fast reel.

Parameters:
- DEB_CYCLES, 50000: consecutive stable cycles needed to accept a new encoder pin level (0.5 ms at 100 MHz).
- WINDOW_CYCLES, 2500000: length of the rate-measurement window in clk cycles (25 ms).
- SCALE, 16: multiplier from steps-per-window to the reel value.
- DECAY, 32: amount `reel` drops per window when the new rate is lower.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- enc_a  in  1  encoder channel A, asynchronous
- enc_b  in  1  encoder channel B, asynchronous
- reel  out  9  smoothed reel rate, 0..511
- reel_valid  out  1  one-cycle pulse on each `reel` update
- step_err  out  1  one-cycle pulse on an illegal quadrature transition

Behaviour:
- Reset (`rst`=0 at a clk edge):
  - `reel`=0, `reel_valid`=0, `step_err`=0.
  - Window counter=0, step count=0, `primed`=0, synchronizer flops=0.
- Synchronizer: 2-flop synchronizer on each pin.
- Debounce (per channel):
  - Counter increments while the synced level differs from the debounced level; it clears when they match.
  - On reaching DEB_CYCLES-1, the debounced level takes the synced level and the counter clears.
- Priming:
  - While `primed`=0, debounced levels load directly from the synced levels and no step is generated.
  - `primed` sets after the first DEB_CYCLES cycles following reset.
- Quadrature decode (x4): compare previous {a,b} with current {a,b} each cycle.
  - Forward sequence 00→01→11→10→00: increment the step count.
  - Reverse sequence: ignored (see Optional Feature).
  - No change: nothing happens.
  - Both bits changed: pulse `step_err` next cycle; step count unchanged.
- Step count: 8 bits, saturates at 255.
- Window counter: counts 0..WINDOW_CYCLES-1 and wraps. On the terminal cycle:
  - raw = min(511, count*SCALE), computed at ≥13-bit width before saturation.
  - If raw ≥ `reel`: `reel` ← raw.
  - Otherwise: `reel` ← (`reel` > DECAY) ? `reel`-DECAY : 0.
  - Count clears. A step landing on the terminal cycle is counted into the next window (count ← 1).
  - `reel_valid`=1 for exactly the following cycle, aligned with the new `reel`.
- Latency: a step affects `reel` at most WINDOW_CYCLES+1 cycles later. Pin-to-decode latency is 2 + DEB_CYCLES cycles.
- Reset mid-window: the partial count is discarded and the window restarts at 0.
- `reel` holds its value between updates.

Optional Feature:
- Macro: REEL_BIDIR_EN.
- Defined:
  - Reverse steps also increment the count, so the rate is a magnitude.
  - Adds output port `dir` (1 bit): 1 if the last counted step in the completed window was reverse; reset value 0.
- Undefined:
  - Reverse steps are ignored.
  - No `dir` port.

Decomposition:
- Package `reel_pkg`:
  - REEL_W=9.
  - REEL_MAX=511.
  - Consumer thresholds REEL_SLOW=288 and REEL_FAST=320.
  - Typedef for the 2-bit quadrature phase, with the forward-successor function.
- Sub-module `encoder_debounce`: synchronizer plus debounce counter for one pin; instantiated twice. Parameter DEB_CYCLES; ports clk, rst, pin, level.

Test Plan:
(Bench parameters: DEB_CYCLES=4, WINDOW_CYCLES=100, SCALE=16, DECAY=32.)
1. Reset with pins held at 11 for 3 cycles, then release → `reel`=0, no `step_err`, no count from priming; first `reel_valid` at cycle 100 with `reel`=0.
2. 20 forward steps, 4 cycles apart, within one window → `reel`=320 with a `reel_valid` pulse; `reel[8:5]`=10.
3. Follow case 2 with idle windows → `reel` goes 288, 256, …, 32, 0, then stays 0.
4. 40 forward steps in one window → `reel`=511 (saturated), not 640 mod 512.
5. 3-cycle glitch on `enc_a` → no step. Pins jump 00→11 and hold → one `step_err` pulse, count unchanged.
6. 10 reverse steps → undefined macro: `reel`=0; REEL_BIDIR_EN: `reel`=160, `dir`=1. Also: reset asserted at cycle 50 of a window holding 15 steps → `reel`=0 and the next update reports only the post-reset steps.
